// File: rtl/slice_detector.sv
// -----------------------------------------------------------------------------
// slice_detector
//   Slice-detection end of one fruit lane. Compares the tracked hand with the
//   fruit position every frame. When enough consecutive fast hand movements
//   pass through the fruit, it latches a direction code and sends it back to
//   the lane's coordinate generator. The code is held until the fruit respawns.
//
// Ports
//   i_vsync        frame clock; all state updates on its rising edge
//   i_reset_n      asynchronous active-low reset
//   i_hand_x/y     tracked hand position, pixels
//   i_hand_valid   hand position valid this frame
//   i_fruit_x/y    fruit top-left position, pixels
//   i_active       fruit is live and sliceable
//   i_new          one-frame pulse: fruit respawned
//   o_slice        0 none, 1 right, 2 left, 3 up, 4 down (held)
//   o_slice_event  one-frame pulse on the frame a slice is confirmed
//   o_swipe        registered: this frame met the speed threshold
// -----------------------------------------------------------------------------
module slice_detector #(
  parameter int unsigned HIT_RADIUS  = 24,
  parameter int unsigned FRUIT_HALF  = 32,
  parameter int unsigned SPEED_MIN   = 12,
  parameter int unsigned HITS_REQ    = 2,
  parameter int unsigned Y_OFFSCREEN = 768
) (
  input  logic       i_vsync,
  input  logic       i_reset_n,
  input  logic [9:0] i_hand_x,
  input  logic [9:0] i_hand_y,
  input  logic       i_hand_valid,
  input  logic [9:0] i_fruit_x,
  input  logic [9:0] i_fruit_y,
  input  logic       i_active,
  input  logic       i_new,
  output logic [2:0] o_slice,
  output logic       o_slice_event,
  output logic       o_swipe
);

  localparam logic [11:0] L_SPEED_MIN = 12'(SPEED_MIN);
  localparam logic [11:0] L_RADIUS    = 12'(HIT_RADIUS);
  localparam logic [10:0] L_HALF      = 11'(FRUIT_HALF);
  localparam logic [10:0] L_Y_OFF     = 11'(Y_OFFSCREEN);
  localparam logic [2:0]  L_HITS      = 3'(HITS_REQ);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_SLICED  = 2'd2
  } state_e;

  state_e      r_state;
  logic [2:0]  r_hit_cnt;
  logic [9:0]  r_prev_x;
  logic [9:0]  r_prev_y;
  logic        r_prev_valid;

  // Motion since the previous frame
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic [10:0]        w_adx;
  logic [10:0]        w_ady;
  logic [11:0]        w_spd;
  logic               w_sw;

  // Hand offset from fruit centre
  logic [10:0]        w_cx;
  logic [10:0]        w_cy;
  logic signed [11:0] w_ex;
  logic signed [11:0] w_ey;
  logic [11:0]        w_aex;
  logic [11:0]        w_aey;
  logic               w_hit;

  logic [2:0]         w_dir;
  logic [2:0]         w_cnt_inc;
  logic               w_qual;

  always_comb begin
    w_dx  = $signed({1'b0, i_hand_x}) - $signed({1'b0, r_prev_x});
    w_dy  = $signed({1'b0, i_hand_y}) - $signed({1'b0, r_prev_y});
    w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
    w_ady = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
    w_spd = {1'b0, w_adx} + {1'b0, w_ady};
    w_sw  = i_hand_valid & r_prev_valid & (w_spd >= L_SPEED_MIN);

    w_cx  = {1'b0, i_fruit_x} + L_HALF;
    w_cy  = {1'b0, i_fruit_y} + L_HALF;
    w_ex  = $signed({2'b00, i_hand_x}) - $signed({1'b0, w_cx});
    w_ey  = $signed({2'b00, i_hand_y}) - $signed({1'b0, w_cy});
    w_aex = w_ex[11] ? 12'(-w_ex) : 12'(w_ex);
    w_aey = w_ey[11] ? 12'(-w_ey) : 12'(w_ey);
    w_hit = i_hand_valid & i_active & ({1'b0, i_fruit_y} < L_Y_OFF)
            & (w_aex <= L_RADIUS) & (w_aey <= L_RADIUS);

    // Ties between axes resolve horizontally
    if (w_adx >= w_ady) begin
      w_dir = w_dx[10] ? 3'd2 : 3'd1;
    end else begin
      w_dir = w_dy[10] ? 3'd3 : 3'd4;
    end

    w_qual    = w_hit & w_sw;
    w_cnt_inc = r_hit_cnt + 3'd1;
  end

  always_ff @(posedge i_vsync or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_ARMED;
      r_hit_cnt     <= 3'd0;
      r_prev_x      <= 10'd0;
      r_prev_y      <= 10'd0;
      r_prev_valid  <= 1'b0;
      o_slice       <= 3'd0;
      o_slice_event <= 1'b0;
      o_swipe       <= 1'b0;
    end else begin
      if (i_hand_valid) begin
        r_prev_x <= i_hand_x;
        r_prev_y <= i_hand_y;
      end
      r_prev_valid  <= i_hand_valid;
      o_swipe       <= w_sw;
      o_slice_event <= 1'b0;

      case (r_state)
        ST_ARMED: begin
          // Respawn wins over a simultaneous qualifying frame
          if (i_new) begin
            r_hit_cnt <= 3'd0;
          end else if (w_qual) begin
            if (3'd1 >= L_HITS) begin
              r_state       <= ST_SLICED;
              r_hit_cnt     <= 3'd0;
              o_slice       <= w_dir;
              o_slice_event <= 1'b1;
            end else begin
              r_state   <= ST_CONFIRM;
              r_hit_cnt <= 3'd1;
            end
          end else begin
            r_hit_cnt <= 3'd0;
          end
        end

        ST_CONFIRM: begin
          if (i_new) begin
            r_state   <= ST_ARMED;
            r_hit_cnt <= 3'd0;
          end else if (w_qual) begin
            if (w_cnt_inc >= L_HITS) begin
              r_state       <= ST_SLICED;
              r_hit_cnt     <= 3'd0;
              o_slice       <= w_dir;
              o_slice_event <= 1'b1;
            end else begin
              r_hit_cnt <= w_cnt_inc;
            end
          end else begin
            r_state   <= ST_ARMED;
            r_hit_cnt <= 3'd0;
          end
        end

        ST_SLICED: begin
          // Code held regardless of active/off-screen until respawn
          if (i_new) begin
            r_state   <= ST_ARMED;
            r_hit_cnt <= 3'd0;
            o_slice   <= 3'd0;
          end
        end

        default: begin
          r_state   <= ST_ARMED;
          r_hit_cnt <= 3'd0;
          o_slice   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_detector.sv
module tb_slice_detector;

  logic       vsync;
  logic       reset_n;
  logic [9:0] hand_x;
  logic [9:0] hand_y;
  logic       hand_valid;
  logic [9:0] fruit_x;
  logic [9:0] fruit_y;
  logic       active;
  logic       new_p;
  logic [2:0] slice;
  logic       slice_event;
  logic       swipe;

  slice_detector dut (
    .i_vsync      (vsync),
    .i_reset_n    (reset_n),
    .i_hand_x     (hand_x),
    .i_hand_y     (hand_y),
    .i_hand_valid (hand_valid),
    .i_fruit_x    (fruit_x),
    .i_fruit_y    (fruit_y),
    .i_active     (active),
    .i_new        (new_p),
    .o_slice      (slice),
    .o_slice_event(slice_event),
    .o_swipe      (swipe)
  );

  typedef struct {
    logic [2:0] sl;
    logic       ev;
    logic       sw;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_n  = 0;
  bit   stim_done = 0;

  initial begin
    vsync = 1'b0;
    forever #5 vsync = ~vsync;
  end

  // Direct output check used around asynchronous reset
  task automatic check_now(input string name, input logic [2:0] es, input logic ee,
                           input logic esw);
    checks++;
    if (slice !== es || slice_event !== ee || swipe !== esw) begin
      errors++;
      $display("FAIL %s: got slice=%0d ev=%0b sw=%0b, want slice=%0d ev=%0b sw=%0b",
               name, slice, slice_event, swipe, es, ee, esw);
    end
  endtask

  // One frame of stimulus plus the expected registered outputs after its edge
  task automatic frame(input int hx, input int hy, input bit hv, input int fx, input int fy,
                       input bit act, input bit nw, input logic [2:0] es, input bit ee,
                       input bit esw);
    exp_t e;
    @(negedge vsync);
    hand_x     = 10'(hx);
    hand_y     = 10'(hy);
    hand_valid = hv;
    fruit_x    = 10'(fx);
    fruit_y    = 10'(fy);
    active     = act;
    new_p      = nw;
    tag_n++;
    e.sl = es; e.ev = ee; e.sw = esw; e.tag = tag_n;
    exp_q.push_back(e);
  endtask

  // Frame against the standard fruit at (300,300), centre (332,332)
  task automatic fr(input int hx, input int hy, input bit hv, input logic [2:0] es,
                    input bit ee, input bit esw);
    frame(hx, hy, hv, 300, 300, 1'b1, 1'b0, es, ee, esw);
  endtask

  task automatic gap(input logic [2:0] es);
    fr(0, 0, 1'b0, es, 1'b0, 1'b0);
  endtask

  task automatic respawn();
    frame(0, 0, 1'b0, 300, 300, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compares each frame's outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge vsync);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (slice !== e.sl || slice_event !== e.ev || swipe !== e.sw) begin
          errors++;
          $display("FAIL frame%0d: got slice=%0d ev=%0b sw=%0b, want slice=%0d ev=%0b sw=%0b",
                   e.tag, slice, slice_event, swipe, e.sl, e.ev, e.sw);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; hand_x = '0; hand_y = '0; hand_valid = 1'b0;
    fruit_x = 10'd300; fruit_y = 10'd300; active = 1'b1; new_p = 1'b0;
    #1;
    check_now("reset", 3'd0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;

    // 1: static hand at centre never swipes
    for (int i = 0; i < 10; i++) fr(332, 332, 1'b1, 3'd0, 1'b0, 1'b0);

    // 2: rightward swipe, slice after third edge, single-frame event
    gap(3'd0);
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd1, 1'b1, 1'b1);
    gap(3'd1);
    // held through further qualifying motion (no re-trigger)
    fr(310, 332, 1'b1, 3'd1, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd1, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd1, 1'b0, 1'b1);
    // 4: respawn clears, same swipe slices again
    respawn();
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd1, 1'b1, 1'b1);
    respawn();

    // 3: left, up, down
    fr(354, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(339, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(324, 332, 1'b1, 3'd2, 1'b1, 1'b1);
    respawn();
    fr(332, 354, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(332, 339, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(332, 324, 1'b1, 3'd3, 1'b1, 1'b1);
    // held while inactive
    frame(0, 0, 1'b0, 300, 300, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    respawn();
    fr(332, 310, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(332, 325, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(332, 340, 1'b1, 3'd4, 1'b1, 1'b1);
    respawn();
    // diagonal tie resolves horizontally: dx=+10, dy=-10
    fr(322, 342, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(332, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(342, 322, 1'b1, 3'd1, 1'b1, 1'b1);
    respawn();

    // 5: inactive fruit and off-screen fruit never slice
    frame(310, 332, 1'b1, 300, 300, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    frame(325, 332, 1'b1, 300, 300, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    frame(340, 332, 1'b1, 300, 300, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    gap(3'd0);
    frame(310, 800, 1'b1, 300, 768, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    frame(325, 800, 1'b1, 300, 768, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    frame(340, 800, 1'b1, 300, 768, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    gap(3'd0);
    // one hit then a miss: run restarts, two more hits needed
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(400, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(355, 332, 1'b1, 3'd1, 1'b1, 1'b1);
    respawn();
    // hand dropout breaks a run
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    gap(3'd0);
    fr(340, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(355, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd2, 1'b1, 1'b1);
    respawn();

    // 6: new coincident with 2nd qualifying frame wins
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    frame(340, 332, 1'b1, 300, 300, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(355, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    gap(3'd0);
    // reset while SLICED clears outputs immediately
    fr(310, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(325, 332, 1'b1, 3'd0, 1'b0, 1'b1);
    fr(340, 332, 1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge vsync);
    reset_n = 1'b0;
    #1;
    check_now("async_reset", 3'd0, 1'b0, 1'b0);
    @(negedge vsync);
    reset_n = 1'b1;
    // prev_valid cleared by reset: no swipe on first frame
    fr(332, 332, 1'b1, 3'd0, 1'b0, 1'b0);
    fr(347, 332, 1'b1, 3'd0, 1'b0, 1'b1);

    repeat (3) @(negedge vsync);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 2000) begin
      @(posedge vsync);
      budget++;
    end
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending=%0d done=%0b, want pending=0 done=1",
               exp_q.size(), stim_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
